// File: rtl/lighting_seq_if.sv
// Board-side bundle for lighting_seq: button/mode switches in, colour code and change strobe out.
interface lighting_seq_if #(
  parameter int WIDTH = 3
);
  logic             button;
  logic [1:0]       mode;
  logic [WIDTH-1:0] colour;
  logic             changed;

  modport master (output button, output mode, input colour, input changed);
  modport slave  (input button, input mode, output colour, output changed);
endinterface

// File: rtl/lighting_seq.sv
// LED colour sequencer: debounced manual stepping, auto forward/reverse stepping, or hold.
// Colour cycles through 1..2^WIDTH-2, never all-zeros or all-ones.
//
// state    | meaning
// MANUAL   | step forward on each debounced press
// AUTO_FWD | step forward every AUTO_DIV cycles
// AUTO_REV | step backward every AUTO_DIV cycles
// HOLD     | colour frozen, prescaler parked at 0
module lighting_seq #(
  parameter int WIDTH    = 3,
  parameter int DEBOUNCE = 4,
  parameter int AUTO_DIV = 8
) (
  input logic          clk,
  input logic          rst,
  lighting_seq_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam int PW = $clog2(AUTO_DIV);
  localparam logic [CW-1:0]    DB_LAST  = CW'(DEBOUNCE - 1);
  localparam logic [PW-1:0]    DIV_LAST = PW'(AUTO_DIV - 1);
  localparam logic [WIDTH-1:0] MIN      = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX      = {{(WIDTH-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    MANUAL   = 2'b00,
    AUTO_FWD = 2'b01,
    AUTO_REV = 2'b10,
    HOLD     = 2'b11
  } mode_t;

  mode_t            state, state_n;
  logic             s1, s2, btn_db, btn_db_d;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    presc, presc_n;
  logic [WIDTH-1:0] colour, colour_n;
  logic             changed, changed_n;
  logic             press, step_fwd, step_rev;

  assign press = btn_db & ~btn_db_d;

  // Debouncer runs in every mode so a button already held when entering manual does not step.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      btn_db   <= 1'b0;
      btn_db_d <= 1'b0;
      cnt      <= '0;
    end else begin
      s1       <= bus.button;
      s2       <= s1;
      btn_db_d <= btn_db;
      if (s2 == btn_db) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        btn_db <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_n   = mode_t'(bus.mode);
    presc_n   = presc;
    colour_n  = colour;
    changed_n = 1'b0;
    step_fwd  = 1'b0;
    step_rev  = 1'b0;
    // A mode change restarts the prescaler and suppresses any step on that edge.
    if (state_n != state) begin
      presc_n = '0;
    end else begin
      case (state)
        MANUAL: begin
          presc_n  = '0;
          step_fwd = press;
        end
        AUTO_FWD, AUTO_REV: begin
          if (presc == DIV_LAST) begin
            presc_n  = '0;
            step_fwd = (state == AUTO_FWD);
            step_rev = (state == AUTO_REV);
          end else begin
            presc_n = presc + 1'b1;
          end
        end
        default: presc_n = '0;
      endcase
    end
    if (step_fwd) begin
      colour_n  = (colour == MAX) ? MIN : colour + 1'b1;
      changed_n = 1'b1;
    end else if (step_rev) begin
      colour_n  = (colour == MIN) ? MAX : colour - 1'b1;
      changed_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= MANUAL;
      presc   <= '0;
      colour  <= MIN;
      changed <= 1'b0;
    end else begin
      state   <= state_n;
      presc   <= presc_n;
      colour  <= colour_n;
      changed <= changed_n;
    end
  end

  assign bus.colour  = colour;
  assign bus.changed = changed;
endmodule
